// File: rtl/ant_datapath_if.sv
// Command/response and VGA pixel bundle between the ant sequencers and the shared executor.
// The master side issues commands; the slave side (ant_datapath) executes them and drives the pixel port.
interface ant_datapath_if #(
    parameter int INSTR_W  = 32,
    parameter int RESULT_W = 16,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [INSTR_W-1:0]  instruction;
    logic                finished;
    logic [RESULT_W-1:0] result;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        output start, instruction,
        input  finished, result, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, instruction,
        output finished, result, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/ant_datapath.sv
// Shared single-command executor for the ant sequencers: LOAD/STORE against a small
// state memory and DRAW of a BLOCK_W x BLOCK_H block on the VGA pixel port.
module ant_datapath #(
    parameter int INSTR_W  = 32,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 12,
    parameter int RESULT_W = 16,
    parameter int MEM_AW   = 8,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int BLOCK_W  = 4,
    parameter int BLOCK_H  = 4
) (
    input  logic           clock,
    input  logic           resetn,
    ant_datapath_if.slave  bus
);

    localparam int MEM_D     = 1 << MEM_AW;
    localparam int CW        = $clog2(BLOCK_W + 1);
    localparam int RW        = $clog2(BLOCK_H + 1);
    localparam int Y_LSB     = 8;
    localparam int COL_LSB   = 15;
    localparam int PLOT_BIT  = 18;
    localparam int DATA_LSB  = 16;

    localparam logic [3:0] OP_DRAW  = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_LOAD_RD,
        S_STORE_WR,
        S_DRAW,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                start_q;
    logic [INSTR_W-1:0]  instr;
    logic [DATA_W-1:0]   mem [0:MEM_D-1];
    logic [DATA_W-1:0]   rd_data;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;

    logic                accept;
    logic                draw_done;
    logic [3:0]          op;
    logic [X_W-1:0]      draw_x;
    logic [Y_W-1:0]      draw_y;
    logic [COLOUR_W-1:0] draw_colour;
    logic                plot_en;
    logic [MEM_AW-1:0]   mem_addr;
    logic [DATA_W-1:0]   store_data;

    function automatic logic [X_W-1:0] wrap_x(input logic [X_W-1:0] base,
                                              input logic [CW-1:0]  off);
        return base + X_W'(off);
    endfunction

    function automatic logic [Y_W-1:0] wrap_y(input logic [Y_W-1:0] base,
                                              input logic [RW-1:0]  off);
        return base + Y_W'(off);
    endfunction

    // Only a rising edge of start in IDLE starts a command; edges while busy are dropped.
    assign accept      = (state == S_IDLE) && bus.start && !start_q;
    assign draw_done   = (row == RW'(BLOCK_H));

    assign op          = instr[INSTR_W-1 -: 4];
    assign draw_x      = instr[X_W-1:0];
    assign draw_y      = instr[Y_LSB +: Y_W];
    assign draw_colour = instr[COL_LSB +: COLOUR_W];
    assign plot_en     = instr[PLOT_BIT];
    // Address bits above MEM_AW alias onto the same word.
    assign mem_addr    = instr[MEM_AW-1:0];
    assign store_data  = instr[DATA_LSB +: DATA_W];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= bus.start;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_DRAW:  state_nxt = plot_en ? S_DRAW : S_DONE;
                    OP_LOAD:  state_nxt = S_LOAD_RD;
                    OP_STORE: state_nxt = S_STORE_WR;
                    default:  state_nxt = S_DONE;
                endcase
            end
            S_LOAD_RD:  state_nxt = S_DONE;
            S_STORE_WR: state_nxt = S_DONE;
            S_DRAW:     if (draw_done) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Command word, memory and read register carry no reset; the FSM gates their use.
    always_ff @(posedge clock) begin
        if (accept)
            instr <= bus.instruction;
        if (state == S_STORE_WR)
            mem[mem_addr] <= store_data;
        if (state == S_LOAD_RD)
            rd_data <= mem[mem_addr];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.finished   <= 1'b1;
            bus.result     <= '0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_plot   <= 1'b0;
            col            <= '0;
            row            <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept)
                        bus.finished <= 1'b0;
                end
                S_EXEC: begin
                    col <= '0;
                    row <= '0;
                end
                S_DRAW: begin
                    // One extra DRAW cycle after the last pixel drops the strobe before DONE.
                    if (!draw_done) begin
                        bus.vga_plot   <= 1'b1;
                        bus.vga_x      <= wrap_x(draw_x, col);
                        bus.vga_y      <= wrap_y(draw_y, row);
                        bus.vga_colour <= draw_colour;
                        if (col == CW'(BLOCK_W - 1)) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                    end else begin
                        bus.vga_plot <= 1'b0;
                    end
                end
                S_DONE: begin
                    bus.finished <= 1'b1;
                    if (op == OP_LOAD)
                        bus.result <= RESULT_W'(rd_data);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ant_datapath.sv
// Directed bench for ant_datapath: reset, handshake, LOAD/STORE aliasing, DRAW scan order and wrap.
module tb_ant_datapath;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_bad;

    ant_datapath_if bus ();

    ant_datapath dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-cycle start pulse; returns just after the accept edge E.
    task automatic issue(input logic [31:0] w);
        bus.start       = 1'b1;
        bus.instruction = w;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic wait_fin(input string tag);
        int i;
        i = 0;
        while (bus.finished !== 1'b1 && i < 50) begin
            tick();
            i++;
        end
        chk(tag, {31'd0, bus.finished}, 32'd1);
    endtask

    task automatic do_load(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        issue({4'd2, 12'd0, addr});
        wait_fin({tag, "_fin"});
        chk(tag, {16'd0, bus.result}, {16'd0, exp});
    endtask

    function automatic logic [31:0] pix(input logic p, input logic [7:0] x,
                                        input logic [6:0] y, input logic [2:0] c);
        return {13'd0, p, x, y, c};
    endfunction

    // Runs a 4x4 DRAW already accepted at E; checks every pixel and the completion timing.
    task automatic check_draw(input string tag, input logic [7:0] x0, input logic [6:0] y0,
                              input logic [2:0] c, input logic [15:0] res, input bit poke);
        logic [7:0] ex;
        logic [6:0] ey;
        tick();
        chk({tag, "_e1_plot"}, {31'd0, bus.vga_plot}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            if (poke && k == 5) begin
                bus.start       = 1'b1;
                bus.instruction = 32'h3777_0010;
            end
            if (poke && k == 8)
                bus.start = 1'b0;
            tick();
            ex = x0 + 8'(k % 4);
            ey = y0 + 7'(k / 4);
            chk($sformatf("%s_px%0d", tag, k),
                pix(bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour), pix(1'b1, ex, ey, c));
            chk($sformatf("%s_busy%0d", tag, k), {31'd0, bus.finished}, 32'd0);
        end
        tick();
        chk({tag, "_e18_plot"}, {31'd0, bus.vga_plot}, 32'd0);
        chk({tag, "_e18_fin"}, {31'd0, bus.finished}, 32'd0);
        tick();
        chk({tag, "_e19_fin"}, {31'd0, bus.finished}, 32'd1);
        chk({tag, "_result"}, {16'd0, bus.result}, {16'd0, res});
        tick();
        tick();
        chk({tag, "_no_retrigger"}, {31'd0, bus.finished}, 32'd1);
    endtask

    initial begin
        int plots;
        n_cmp           = 0;
        n_bad           = 0;
        resetn          = 1'b0;
        bus.start       = 1'b0;
        bus.instruction = '0;
        tick();
        tick();
        chk("rst_finished", {31'd0, bus.finished}, 32'd1);
        chk("rst_result", {16'd0, bus.result}, 32'd0);
        chk("rst_pixel", pix(bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour), 32'd0);
        resetn = 1'b1;
        tick();

        // NOP with start held high: one command only, finished after E+2.
        bus.start       = 1'b1;
        bus.instruction = 32'h0000_0000;
        tick();
        chk("nop_e0", {31'd0, bus.finished}, 32'd0);
        tick();
        chk("nop_e1", {31'd0, bus.finished}, 32'd0);
        tick();
        chk("nop_e2", {31'd0, bus.finished}, 32'd1);
        tick();
        chk("nop_held_e3", {31'd0, bus.finished}, 32'd1);
        tick();
        chk("nop_held_e4", {31'd0, bus.finished}, 32'd1);
        bus.start = 1'b0;
        tick();

        // STORE 0x0AB to 0x0010: finished after E+3, result untouched.
        issue(32'h30AB_0010);
        tick();
        tick();
        chk("st_e2", {31'd0, bus.finished}, 32'd0);
        tick();
        chk("st_e3", {31'd0, bus.finished}, 32'd1);
        chk("st_result", {16'd0, bus.result}, 32'd0);

        // LOAD 0x0010: result and finished together after E+3.
        issue(32'h2000_0010);
        tick();
        tick();
        chk("ld_e2_fin", {31'd0, bus.finished}, 32'd0);
        chk("ld_e2_res", {16'd0, bus.result}, 32'd0);
        tick();
        chk("ld_e3_fin", {31'd0, bus.finished}, 32'd1);
        chk("ld_e3_res", {16'd0, bus.result}, 32'h0000_00AB);

        // Address aliasing through the low MEM_AW bits.
        issue(32'h3123_0105);
        wait_fin("alias_st_fin");
        do_load("alias_ld5", 16'h0005, 16'h0123);
        do_load("alias_ld10", 16'h0010, 16'h00AB);

        // DRAW x=250 y=10 colour=4 with a busy start edge that must be ignored.
        issue(32'h1006_0AFA);
        check_draw("draw", 8'd250, 7'd10, 3'b100, 16'h00AB, 1'b1);
        do_load("ignored_store", 16'h0010, 16'h00AB);

        // DRAW wrapping both coordinates.
        issue(32'h1005_FEFE);
        check_draw("wrap", 8'd254, 7'd126, 3'b011, 16'h00AB, 1'b0);

        // DRAW with plot_en=0 behaves as NOP.
        issue(32'h1002_0AFA);
        plots = 0;
        tick();
        plots += int'(bus.vga_plot);
        tick();
        plots += int'(bus.vga_plot);
        chk("noplot_e2_fin", {31'd0, bus.finished}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            plots += int'(bus.vga_plot);
        end
        chk("noplot_count", 32'(plots), 32'd0);

        // Opcode 7: NOP timing, no memory change.
        issue(32'h7FFF_0010);
        tick();
        chk("op7_e1", {31'd0, bus.finished}, 32'd0);
        tick();
        chk("op7_e2", {31'd0, bus.finished}, 32'd1);
        chk("op7_plot", {31'd0, bus.vga_plot}, 32'd0);
        do_load("op7_mem", 16'h0010, 16'h00AB);

        // Reset after the 5th pixel of a DRAW aborts immediately.
        issue(32'h1007_8000);
        tick();
        repeat (5) tick();
        chk("abort_plot_before", {31'd0, bus.vga_plot}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("abort_plot", {31'd0, bus.vga_plot}, 32'd0);
        chk("abort_fin", {31'd0, bus.finished}, 32'd1);
        chk("abort_result", {16'd0, bus.result}, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        plots  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            plots += int'(bus.vga_plot);
        end
        chk("abort_no_pixels", 32'(plots), 32'd0);
        chk("abort_idle_fin", {31'd0, bus.finished}, 32'd1);
        do_load("mem_kept", 16'h0010, 16'h00AB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ant_datapath.md
Name: ant_datapath

Overview:
- Shared instruction executor that sits directly downstream of the ant draw/update sequencers. It consumes their start_dp/instruction_dp command stream and returns finished_dp/result_dp.
- Executes three operations:
  - load a word from a small on-chip state memory;
  - store a word into that memory;
  - plot a BLOCK_W x BLOCK_H coloured block on the VGA pixel interface.
- One command is in flight at a time; there is no queue.

Parameters:
- INSTR_W, 32, instruction width.
- ADDR_W, 16, address field width, instr[15:0].
- DATA_W, 12, store data field width, instr[27:16].
- RESULT_W, 16, result width; load data is zero-extended to this width.
- MEM_AW, 8, log2 of memory depth (256 words x DATA_W); address field is truncated to its low MEM_AW bits.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 3, colour width.
- BLOCK_W, 4, block width in pixels.
- BLOCK_H, 4, block height in pixels.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  command request; a command is accepted on a rising edge of start only.
- instruction  in  INSTR_W  command word; must be valid in the cycle start rises.
- finished  out  1  high = idle/done; low while a command executes.
- result  out  RESULT_W  last load result.
- vga_x  out  X_W  pixel x.
- vga_y  out  Y_W  pixel y.
- vga_colour  out  COLOUR_W  pixel colour.
- vga_plot  out  1  pixel write strobe.

Behaviour:
- Reset (asynchronous, resetn=0), all outputs and state cleared:
  - finished=1, result=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, state=IDLE, start_q=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation aborts immediately: no further pixels, no pending write. The block is IDLE on release.
- Accept condition:
  - Internal start_q = start delayed one cycle.
  - Accept at edge E iff state==IDLE and start=1 and start_q=0.
  - At E: instruction is latched and finished<=0.
  - Start held high for several cycles (clients hold it 2 cycles) yields exactly one command.
  - A rising edge of start while busy is ignored and is not remembered.
- Decode, opcode = instr[31:28]:
  - 0 = NOP.
  - 1 = DRAW: x=instr[7:0], y=instr[14:8], colour=instr[17:15], plot_en=instr[18].
  - 2 = LOAD: addr=instr[15:0].
  - 3 = STORE: data=instr[27:16], addr=instr[15:0].
  - 4..15 = treated as NOP.
- States: IDLE, EXEC (dispatch), LOAD_RD, STORE_WR, DRAW, DONE.
  - DONE sets finished<=1 and returns to IDLE.
- Latency, with E = accept edge; finished is high after:
  - NOP: E+2.
  - STORE: memory written at E+2; finished high after E+3.
  - LOAD: synchronous read; result updated together with finished after E+3.
  - DRAW with plot_en=1: vga_plot=1 for exactly BLOCK_W*BLOCK_H consecutive cycles starting after E+2; finished high one cycle after the last pixel (16 pixels -> after E+19).
  - DRAW with plot_en=0: behaves as NOP.
- Draw scan order:
  - Row-major: column counter 0..BLOCK_W-1 inner, row counter 0..BLOCK_H-1 outer.
  - vga_x = x+col mod 2^X_W; vga_y = y+row mod 2^Y_W (wrap, no clipping).
  - vga_colour is constant for the whole block.
  - vga_plot=0 at all other times; vga_x/vga_y/vga_colour hold their last values when not plotting.
- Result: changes only on LOAD completion. STORE, DRAW and NOP leave it unchanged.
- Data paths:
  - Loaded data is zero-extended to RESULT_W.
  - Store data is exactly DATA_W bits.
  - Upper address bits [15:MEM_AW] are ignored (aliasing).
- Load of an address never written returns an unspecified value.
- Load immediately following a store to the same address returns the stored value; there is no bypass hazard because the store completes first.

Test Plan:
- Reset: assert resetn=0 mid-DRAW (after the 5th pixel) -> vga_plot=0 and finished=1 immediately; no more pixels after release.
- STORE then LOAD: STORE {3, 12'h0AB, 16'h0010}, then LOAD {2, 12'd0, 16'h0010} -> result=16'h00AB, finished rises 3 cycles after the accept edge.
- Address alias: STORE 12'h123 to addr 16'h0105, then LOAD addr 16'h0005 -> result=16'h0123. LOAD addr 16'h0010 still returns 16'h00AB.
- DRAW: x=8'd250, y=7'd10, colour=3'b100, plot_en=1 -> 16 plot cycles covering x=250..253, y=10..13 in row-major order; then finished=1 with result unchanged.
- Wrap: DRAW x=254, y=126 -> x sequence 254, 255, 0, 1 and y sequence 126, 127, 0, 1.
- Handshake:
  - start held high for 2 cycles -> exactly one command executes.
  - A new start rising edge during a DRAW is ignored.
  - Opcode 7 -> finished after E+2 with no plot and no memory change.
  - DRAW with plot_en=0 -> no vga_plot pulse.
